// File: rtl/gray_ptr_sync_decode_if.sv
// Bundle for a Gray pointer crossing in from a foreign clock domain and its decoded view.
// The source side drives gray_in/resync/error_clear; the receiver returns the decoded outputs.
interface gray_ptr_sync_decode_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] gray_in;
  logic             resync;
  logic             error_clear;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] binary_out;
  logic [WIDTH-1:0] delta;
  logic             changed;
  logic             multi_bit_error;

  modport master (
    output gray_in, resync, error_clear,
    input  gray_out, binary_out, delta, changed, multi_bit_error
  );

  modport slave (
    input  gray_in, resync, error_clear,
    output gray_out, binary_out, delta, changed, multi_bit_error
  );
endinterface

// File: rtl/gray_ptr_sync_decode.sv
// Synchronises a foreign-domain Gray pointer, decodes it to binary, and reports advance/change/error.
// Latency SYNC_STAGES+1 edges from gray_in to outputs; no backpressure, outputs valid every cycle.
module gray_ptr_sync_decode #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  gray_ptr_sync_decode_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] gray_out_q, gray_out_d;
  logic [WIDTH-1:0] binary_out_q, binary_out_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             changed_q, changed_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] gray_sync;
  logic [WIDTH-1:0] bin_sync;
  logic [WIDTH-1:0] gray_diff;
  logic             multi_bit;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign gray_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    bin_sync            = '0;
    bin_sync[WIDTH-1]   = gray_sync[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_sync[i] = bin_sync[i+1] ^ gray_sync[i];
    end
  end

  // More than one bit set in the difference <=> clearing the lowest set bit leaves something.
  assign gray_diff = gray_sync ^ gray_out_q;
  assign multi_bit = |(gray_diff & (gray_diff - ONE));

  always_comb begin
    gray_out_d   = gray_sync;
    binary_out_d = bin_sync;
    changed_d    = (gray_sync != gray_out_q);
    delta_d      = bus.resync ? '0 : (bin_sync - binary_out_q);
    err_d        = err_q;
    if (multi_bit && !bus.resync) begin
      err_d = 1'b1;
    end else if (bus.error_clear) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      gray_out_q   <= '0;
      binary_out_q <= '0;
      delta_q      <= '0;
      changed_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      gray_out_q   <= gray_out_d;
      binary_out_q <= binary_out_d;
      delta_q      <= delta_d;
      changed_q    <= changed_d;
      err_q        <= err_d;
    end
  end

  assign bus.gray_out        = gray_out_q;
  assign bus.binary_out      = binary_out_q;
  assign bus.delta           = delta_q;
  assign bus.changed         = changed_q;
  assign bus.multi_bit_error = err_q;

endmodule

// File: tb/tb_gray_ptr_sync_decode.sv
// Directed bench for gray_ptr_sync_decode with a history-based reference model checked every cycle.
module tb_gray_ptr_sync_decode;

  localparam int W = 4;
  localparam int S = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic chk_en  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  gray_ptr_sync_decode_if #(.WIDTH(W)) bus ();

  gray_ptr_sync_decode #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  logic [W-1:0] walk [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: decode by searching for the integer whose Gray code matches.
  function automatic logic [W-1:0] model_decode(input logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < (1 << W); i++) begin
      if ((i ^ (i >> 1)) == int'(g)) r = i[W-1:0];
    end
    return r;
  endfunction

  logic [W-1:0] hist [$];
  logic [W-1:0] m_gray    = '0;
  logic [W-1:0] m_bin     = '0;
  logic [W-1:0] m_delta   = '0;
  logic         m_changed = 1'b0;
  logic         m_err     = 1'b0;
  logic [W-1:0] m_gs;
  logic [W-1:0] m_nb;

  // Output after edge n reflects the gray_in seen S edges earlier (0 before that since reset).
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      m_gray    = '0;
      m_bin     = '0;
      m_delta   = '0;
      m_changed = 1'b0;
      m_err     = 1'b0;
    end else begin
      hist.push_back(bus.gray_in);
      m_gs      = (hist.size() > S) ? hist[hist.size() - 1 - S] : '0;
      m_nb      = model_decode(m_gs);
      m_changed = (m_gs != m_gray);
      m_delta   = bus.resync ? '0 : W'(m_nb - m_bin);
      if ($countones(m_gs ^ m_gray) > 1 && !bus.resync) m_err = 1'b1;
      else if (bus.error_clear)                         m_err = 1'b0;
      m_gray    = m_gs;
      m_bin     = m_nb;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_gray_out",   bus.gray_out,               m_gray);
      check("model_binary_out", bus.binary_out,             m_bin);
      check("model_delta",      bus.delta,                  m_delta);
      check("model_changed",    W'(bus.changed),            W'(m_changed));
      check("model_error",      W'(bus.multi_bit_error),    W'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  initial begin
    bus.gray_in     = '0;
    bus.resync      = 1'b0;
    bus.error_clear = 1'b0;

    // Reset held with a nonzero foreign pointer
    #1;
    reset_n     = 1'b0;
    bus.gray_in = 4'b0110;
    chk_en      = 1'b1;
    tick(3);
    check("rst_gray_out",   bus.gray_out,               4'h0);
    check("rst_binary_out", bus.binary_out,             4'h0);
    check("rst_delta",      bus.delta,                  4'h0);
    check("rst_changed",    W'(bus.changed),            4'h0);
    check("rst_error",      W'(bus.multi_bit_error),    4'h0);
    reset_n     = 1'b1;
    bus.gray_in = 4'b0000;
    tick(3);

    // Full walk; first step pins latency
    bus.gray_in = walk[1];
    tick(2);
    check("lat_before", bus.binary_out, 4'h0);
    tick(1);
    check("lat_binary", bus.binary_out,     4'h1);
    check("lat_delta",  bus.delta,          4'h1);
    check("lat_changed", W'(bus.changed),   4'h1);
    for (int i = 2; i < 16; i++) begin
      bus.gray_in = walk[i];
      tick(2);
    end
    bus.gray_in = 4'b0000;
    tick(3);
    check("wrap_binary",  bus.binary_out,            4'h0);
    check("wrap_delta",   bus.delta,                 4'h1);
    check("wrap_changed", W'(bus.changed),           4'h1);
    check("walk_error",   W'(bus.multi_bit_error),   4'h0);
    tick(2);

    // Illegal two-bit jump 0000 -> 0011
    bus.gray_in = 4'b0011;
    tick(3);
    check("jump_binary",  bus.binary_out,            4'h2);
    check("jump_delta",   bus.delta,                 4'h2);
    check("jump_changed", W'(bus.changed),           4'h1);
    check("jump_error",   W'(bus.multi_bit_error),   4'h1);
    tick(3);
    check("jump_sticky",  W'(bus.multi_bit_error),   4'h1);
    check("hold_delta",   bus.delta,                 4'h0);

    // Clear in a quiet cycle
    bus.error_clear = 1'b1;
    tick(1);
    check("clear_quiet", W'(bus.multi_bit_error), 4'h0);
    bus.error_clear = 1'b0;

    // Resync on the update edge of 0011 -> 1100
    bus.gray_in = 4'b1100;
    tick(2);
    bus.resync = 1'b1;
    tick(1);
    check("resync_binary",  bus.binary_out,          4'h8);
    check("resync_delta",   bus.delta,               4'h0);
    check("resync_changed", W'(bus.changed),         4'h1);
    check("resync_error",   W'(bus.multi_bit_error), 4'h0);
    bus.resync = 1'b0;
    tick(1);
    check("post_resync_delta",   bus.delta,          4'h0);
    check("post_resync_changed", W'(bus.changed),    4'h0);

    // Set wins over simultaneous clear: 1100 -> 1111
    bus.gray_in     = 4'b1111;
    bus.error_clear = 1'b1;
    tick(3);
    check("setclr_error",  W'(bus.multi_bit_error), 4'h1);
    check("setclr_binary", bus.binary_out,          4'ha);
    check("setclr_delta",  bus.delta,               4'h2);
    bus.error_clear = 1'b0;

    // Step back to binary 9, then reset mid-cycle
    bus.gray_in = 4'b1101;
    tick(3);
    check("b9_binary", bus.binary_out, 4'h9);
    check("b9_delta",  bus.delta,      4'hf);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_gray_out",   bus.gray_out,             4'h0);
    check("async_binary_out", bus.binary_out,           4'h0);
    check("async_delta",      bus.delta,                4'h0);
    check("async_changed",    W'(bus.changed),          4'h0);
    check("async_error",      W'(bus.multi_bit_error),  4'h0);
    bus.resync = 1'b1;
    #1;
    reset_n = 1'b1;
    tick(3);
    check("rel_gray_out", bus.gray_out,               4'hd);
    check("rel_binary",   bus.binary_out,             4'h9);
    check("rel_delta",    bus.delta,                  4'h0);
    check("rel_changed",  W'(bus.changed),            4'h1);
    check("rel_error",    W'(bus.multi_bit_error),    4'h0);
    bus.resync = 1'b0;
    tick(1);
    check("rel_hold_delta",   bus.delta,              4'h0);
    check("rel_hold_changed", W'(bus.changed),        4'h0);
    check("rel_hold_binary",  bus.binary_out,         4'h9);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
